retire_trace_monitor: RTL

//  Sits directly downstream of the CPU core's retire point; consumes one retirement record per cycle
//  (PC, instr, rd writeback). Buffers records in a FIFO for the bench/trace dump and counts

---
 rtl/retire_trace_monitor_if.sv | 28 ++
 rtl/retire_trace_monitor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/retire_trace_monitor_if.sv
// Retirement record in from the core, trace record out to the consumer.
// The monitor takes the slave view; the retire source / trace consumer the master view.
interface retire_trace_monitor_if;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic        ret_we;
  logic [4:0]  ret_rd;
  logic [31:0] ret_wdata;

  logic        tr_ready;
  logic        tr_valid;
  logic [31:0] tr_pc;
  logic [31:0] tr_instr;
  logic        tr_we;
  logic [4:0]  tr_rd;
  logic [31:0] tr_wdata;

  modport master (
    output ret_valid, ret_pc, ret_instr, ret_we, ret_rd, ret_wdata, tr_ready,
    input  tr_valid, tr_pc, tr_instr, tr_we, tr_rd, tr_wdata
  );

  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_we, ret_rd, ret_wdata, tr_ready,
    output tr_valid, tr_pc, tr_instr, tr_we, tr_rd, tr_wdata
  );
endinterface

// File: rtl/retire_trace_monitor.sv
// Buffers retirement records for trace dump, counts cycles/retirements and flags
// end of test (halt PC or cycle budget), then drains the buffer before raising done.
module retire_trace_monitor #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] HALT_PC    = 32'h48,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  retire_trace_monitor_if.slave bus,
  output logic                  halt_hit,
  output logic                  timeout,
  output logic                  overflow,
  output logic                  done,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           retire_cnt
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rec_t;

  rec_t        mem_q [DEPTH];
  state_e      state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        halt_q, halt_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d, retire_cnt_q, retire_cnt_d;

  logic fifo_empty, fifo_full, in_run, pop, push, drop;
  rec_t wr_rec, head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign in_run     = (state_q == S_RUN);
  assign pop        = !fifo_empty && bus.tr_ready && (state_q != S_DONE);
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push       = in_run && bus.ret_valid && (!fifo_full || pop);
  assign drop       = in_run && bus.ret_valid && fifo_full && !pop;

  assign wr_rec = '{pc: bus.ret_pc, instr: bus.ret_instr, we: bus.ret_we,
                    rd: bus.ret_rd, wdata: bus.ret_wdata};
  assign head   = mem_q[rd_ptr_q];

  assign bus.tr_valid = !fifo_empty;
  assign bus.tr_pc    = head.pc;
  assign bus.tr_instr = head.instr;
  assign bus.tr_we    = head.we;
  assign bus.tr_rd    = head.rd;
  assign bus.tr_wdata = head.wdata;

  assign halt_hit   = halt_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
  assign done       = (state_q == S_DONE);
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    halt_d       = halt_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: ;
    endcase

    unique case (state_q)
      S_RUN: begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (bus.ret_valid && retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + 32'd1;
        if (drop) overflow_d = 1'b1;
        // Halt outranks timeout; a dropped halt record still ends the run.
        if (bus.ret_valid && bus.ret_pc == HALT_PC) begin
          halt_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (cycle_cnt_q == LAST_CYCLE) begin
          timeout_d = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= S_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      halt_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      halt_q       <= halt_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

endmodule
